dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data RAM between two requesters: the pipeline memory stage (port M) and the debug/program-loader port (port D). Runs one transaction at a time: arbitration, one-cycle RAM strobe, programmable read-latency wait, then a one-cycle completion pulse to the owner. Sits between memory_access-style request logic and the ram instance, which it drives through read_en/write_en/addr/write_data.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
RD_LAT, 0, cycles from the RAM strobe cycle to the rdata/err sample cycle (legal 0..7)
STARVE_MAX, 4, consecutive M grants while D is waiting before D is forced to win (legal 1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
m_req_i  in  1  port M request
m_we_i  in  1  port M: 1 = write, 0 = read
m_addr_i  in  ADDR_W  port M address
m_wdata_i  in  DATA_W  port M write data
m_gnt_o  out  1  port M granted (request captured this cycle)
m_done_o  out  1  port M transaction complete (one-cycle pulse)
m_rdata_o  out  DATA_W  port M read data, valid with m_done_o
m_err_o  out  1  port M error, valid with m_done_o
d_req_i, d_we_i, d_addr_i, d_wdata_i, d_gnt_o, d_done_o, d_rdata_o, d_err_o: same as the port M signals, for port D
ram_read_en_o  out  1  RAM read strobe
ram_write_en_o  out  1  RAM write strobe
ram_addr_o  out  ADDR_W  RAM address
ram_wdata_o  out  DATA_W  RAM write data
ram_rdata_i  in  DATA_W  RAM read data
ram_err_i  in  1  RAM error (dmem_error)
busy_o  out  1  high when state != IDLE

Behaviour:
- Clock/reset: one clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset: state=IDLE, starvation counter=0, latched owner/op/addr/wdata=0, and all outputs 0, including rdata.
- Reset mid-transaction: return to IDLE immediately. Strobes drop asynchronously. No done pulse is issued. A write in progress has undefined RAM effect.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if m_req_i or d_req_i is high, pick a winner and assert its gnt_o combinationally in this cycle.
  - Same edge: latch owner, we, addr, wdata, then go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration:
  - M wins by default.
  - D wins when only D requests, or when both request and starve_cnt >= STARVE_MAX.
  - starve_cnt increments when M is granted while d_req_i is high (saturating at 15).
  - starve_cnt clears when D is granted or when d_req_i is low in IDLE.
- ISSUE: exactly one cycle with ram_write_en_o = latched we, ram_read_en_o = !we, and addr/wdata from the latches.
  - Strobes are 0 in every other state.
  - ram_addr_o/ram_wdata_o hold the latched values in ISSUE, WAIT and RESP, and read 0 in IDLE.
- Writes: sample ram_err_i in ISSUE, then go to RESP.
- Reads, RD_LAT=0: sample ram_rdata_i and ram_err_i in ISSUE, then go to RESP.
- Reads, RD_LAT>0: go to WAIT with wcnt=RD_LAT. Decrement wcnt each cycle; sample when wcnt==1, then go to RESP.
- RESP: the owner's done_o=1 for one cycle, with its rdata_o/err_o from the sample registers.
  - rdata_o is 0 for writes.
  - The non-owner's rdata_o/err_o hold 0.
  - Next state is always IDLE; no grant is issued in RESP.
- Latency, from request seen in IDLE at cycle T:
  - write: done at T+2
  - read: done at T+2+RD_LAT
  - throughput: one transaction per 3+RD_LAT cycles minimum
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt; they may change freely after gnt.
  - A request still high at the IDLE following RESP is treated as a new transaction.
- Dropping req before gnt cancels it with no side effects.
- Simultaneous requests resolve by the arbitration rule only; no tie ever grants both ports.
- Invariants (asserted in the bench):
  - at most one gnt_o per cycle
  - at most one done_o per cycle
  - never ram_read_en_o && ram_write_en_o

Decomposition:
- Shared define.v gets:
  - state encodings (`ARB_IDLE, `ARB_ISSUE, `ARB_WAIT, `ARB_RESP, 2 bits)
  - owner IDs (`ARB_PORT_M=1'b0, `ARB_PORT_D=1'b1)
- One natural sub-module: dmem_arb_pick. It holds the starvation counter plus the winner-select logic, with inputs m_req, d_req, idle, and outputs grant_m, grant_d.

Test Plan:
- M write: m_req, we=1, addr=0x100, wdata=0xDEADBEEF -> m_gnt at T, ram_write_en_o=1 at T+1 with addr 0x100, m_done at T+2, m_err=0, m_rdata=0.
- M read, RD_LAT=2, RAM returns 0x1234 -> ram_read_en_o at T+1 only, m_done at T+4 with m_rdata=0x1234, busy_o high T+1..T+4.
- Both ports hold requests continuously, STARVE_MAX=4 -> grant order M,M,M,M,D,M,...; never two gnts in a cycle.
- Only d_req, read of addr 0x8 with ram_err_i=1 at the sample cycle -> d_done with d_err=1; m_done stays 0.
- Async reset pulsed during WAIT -> all outputs 0 immediately, state IDLE, no done; a subsequent M read completes normally.
- m_req drops before gnt, because D holds the bus -> no M transaction occurs, and the next IDLE grants nothing to M.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings and port IDs for the data-memory arbiter
package dmem_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;
   localparam logic ARB_PORT_M = 1'b0;
   localparam logic ARB_PORT_D = 1'b1;
   localparam logic [3:0] STARVE_SAT = 4'hF;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: M-priority winner select with a starvation counter that forces D through
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic m_req,
   input  logic d_req,
   input  logic idle,
   output logic grant_m,
   output logic grant_d
);
   logic [3:0] starve_cnt;
   assign grant_d = idle && d_req && (!m_req || starve_cnt >= 4'(STARVE_MAX));
   assign grant_m = idle && m_req && !grant_d;
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) starve_cnt <= '0;
      else if (idle) begin
         if (grant_d || !d_req) starve_cnt <= '0;
         else if (grant_m && starve_cnt != STARVE_SAT) starve_cnt <= starve_cnt + 4'd1;
      end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the memory stage (M) and the debug port (D),
// one transaction at a time: grant, one-cycle strobe, read-latency wait, completion pulse.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int RD_LAT     = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              m_req_i,
   input  logic              m_we_i,
   input  logic [ADDR_W-1:0] m_addr_i,
   input  logic [DATA_W-1:0] m_wdata_i,
   output logic              m_gnt_o,
   output logic              m_done_o,
   output logic [DATA_W-1:0] m_rdata_o,
   output logic              m_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_done_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_err_o,
   output logic              ram_read_en_o,
   output logic              ram_write_en_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   input  logic              ram_err_i,
   output logic              busy_o
);
   arb_state_t        state;
   logic              owner;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] samp_rdata;
   logic              samp_err;
   logic [2:0]        wcnt;
   logic              idle;
   logic              grant_m;
   logic              grant_d;
   logic              issue;
   logic              resp;

   assign idle  = state == ARB_IDLE;
   assign issue = state == ARB_ISSUE;
   assign resp  = state == ARB_RESP;

   dmem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .m_req   (m_req_i),
      .d_req   (d_req_i),
      .idle    (idle),
      .grant_m (grant_m),
      .grant_d (grant_d)
   );

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state      <= ARB_IDLE;
         owner      <= ARB_PORT_M;
         we         <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         samp_rdata <= '0;
         samp_err   <= 1'b0;
         wcnt       <= '0;
      end else
         case (state)
            ARB_IDLE:
               if (grant_m || grant_d) begin
                  owner <= grant_d ? ARB_PORT_D : ARB_PORT_M;
                  we    <= grant_d ? d_we_i : m_we_i;
                  addr  <= grant_d ? d_addr_i : m_addr_i;
                  wdata <= grant_d ? d_wdata_i : m_wdata_i;
                  state <= ARB_ISSUE;
               end
            ARB_ISSUE:
               if (we || RD_LAT == 0) begin
                  samp_rdata <= we ? '0 : ram_rdata_i;
                  samp_err   <= ram_err_i;
                  state      <= ARB_RESP;
               end else begin
                  wcnt  <= 3'(RD_LAT);
                  state <= ARB_WAIT;
               end
            ARB_WAIT:
               if (wcnt == 3'd1) begin
                  samp_rdata <= ram_rdata_i;
                  samp_err   <= ram_err_i;
                  state      <= ARB_RESP;
               end else wcnt <= wcnt - 3'd1;
            default: state <= ARB_IDLE;
         endcase

   // Strobes and completion are decoded from registered state only, so reset drops them at once.
   assign m_gnt_o        = grant_m;
   assign d_gnt_o        = grant_d;
   assign ram_read_en_o  = issue && !we;
   assign ram_write_en_o = issue && we;
   assign ram_addr_o     = idle ? '0 : addr;
   assign ram_wdata_o    = idle ? '0 : wdata;
   assign m_done_o       = resp && owner == ARB_PORT_M;
   assign d_done_o       = resp && owner == ARB_PORT_D;
   assign m_rdata_o      = m_done_o ? samp_rdata : '0;
   assign d_rdata_o      = d_done_o ? samp_rdata : '0;
   assign m_err_o        = m_done_o && samp_err;
   assign d_err_o        = d_done_o && samp_err;
   assign busy_o         = !idle;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus checked against a transaction-level model.
module tb_dmem_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int RL = 2;
   localparam int SM = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b1;
   logic          m_req_i = 0, m_we_i = 0, d_req_i = 0, d_we_i = 0;
   logic [AW-1:0] m_addr_i = '0, d_addr_i = '0;
   logic [DW-1:0] m_wdata_i = '0, d_wdata_i = '0, ram_rdata_i = '0;
   logic          ram_err_i = 0;
   logic          m_gnt_o, m_done_o, m_err_o, d_gnt_o, d_done_o, d_err_o;
   logic [DW-1:0] m_rdata_o, d_rdata_o, ram_wdata_o;
   logic [AW-1:0] ram_addr_o;
   logic          ram_read_en_o, ram_write_en_o, busy_o;

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(SM)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
      .m_gnt_o(m_gnt_o), .m_done_o(m_done_o), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_done_o(d_done_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .ram_read_en_o(ram_read_en_o), .ram_write_en_o(ram_write_en_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
      .ram_rdata_i(ram_rdata_i), .ram_err_i(ram_err_i), .busy_o(busy_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one in-flight transaction tracked by its age in cycles since grant.
   logic          a_act, a_own, a_we, a_se;
   logic [63:0]   a_addr, a_wd, a_sr;
   int            a_age, a_starve;
   logic          e_gm = 0, e_gd = 0;
   logic          got_gm, got_gd, got_md, got_dd, got_me, got_de;
   logic [63:0]   got_mr, got_dr;

   function automatic int done_age(input logic w);
      return w ? 2 : 2 + RL;
   endfunction

   task automatic model_reset();
      a_act = 0; a_own = 0; a_we = 0; a_se = 0;
      a_addr = '0; a_wd = '0; a_sr = '0;
      a_age = 0; a_starve = 0; e_gm = 0; e_gd = 0;
   endtask

   task automatic step();
      logic xm, xd, xrd, xwr;
      logic [63:0] xr;
      @(negedge clk_i);
      e_gd = !a_act && d_req_i && (!m_req_i || a_starve >= SM);
      e_gm = !a_act && m_req_i && !e_gd;
      xm   = a_act && a_age == done_age(a_we) && !a_own;
      xd   = a_act && a_age == done_age(a_we) && a_own;
      xrd  = a_act && a_age == 1 && !a_we;
      xwr  = a_act && a_age == 1 && a_we;
      xr   = a_we ? 64'd0 : a_sr;
      got_gm = m_gnt_o; got_gd = d_gnt_o; got_md = m_done_o; got_dd = d_done_o;
      got_mr = m_rdata_o; got_dr = d_rdata_o; got_me = m_err_o; got_de = d_err_o;
      assert (!(m_gnt_o && d_gnt_o)) else $error("two grants in one cycle");
      assert (!(m_done_o && d_done_o)) else $error("two completions in one cycle");
      assert (!(ram_read_en_o && ram_write_en_o)) else $error("read and write strobe together");
      chk("m_gnt", m_gnt_o, e_gm);
      chk("d_gnt", d_gnt_o, e_gd);
      chk("ram_rd", ram_read_en_o, xrd);
      chk("ram_wr", ram_write_en_o, xwr);
      chk("ram_addr", ram_addr_o, a_act ? a_addr : 64'd0);
      chk("ram_wdata", ram_wdata_o, a_act ? a_wd : 64'd0);
      chk("busy", busy_o, a_act);
      chk("m_done", m_done_o, xm);
      chk("d_done", d_done_o, xd);
      chk("m_rdata", m_rdata_o, xm ? xr : 64'd0);
      chk("d_rdata", d_rdata_o, xd ? xr : 64'd0);
      chk("m_err", m_err_o, xm && a_se);
      chk("d_err", d_err_o, xd && a_se);
      if (a_act) begin
         if (a_age == done_age(a_we) - 1) begin a_sr = ram_rdata_i; a_se = ram_err_i; end
         if (a_age == done_age(a_we)) a_act = 0;
         else a_age++;
      end else begin
         if (e_gm || e_gd) begin
            a_act = 1; a_age = 1; a_own = e_gd;
            a_we   = e_gd ? d_we_i : m_we_i;
            a_addr = e_gd ? d_addr_i : m_addr_i;
            a_wd   = e_gd ? d_wdata_i : m_wdata_i;
         end
         a_starve = (e_gd || !d_req_i) ? 0 : (e_gm ? (a_starve < 15 ? a_starve + 1 : 15) : a_starve);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic run_until_done(input string tag, output int lat);
      lat = 0;
      do begin step(); lat++; end while (!(got_md || got_dd) && lat < 20);
      if (!(got_md || got_dd)) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic rnd_port(input logic req, input logic gnt, input logic we, input logic [63:0] ad,
                           input logic [63:0] wd, output logic req_n, output logic we_n,
                           output logic [63:0] ad_n, output logic [63:0] wd_n);
      req_n = req; we_n = we; ad_n = ad; wd_n = wd;
      if (req && !gnt) begin
         if ($urandom_range(0, 19) == 0) req_n = 0;
      end else begin
         req_n = $urandom_range(0, 1) == 0;
         if (req_n) begin
            we_n = 1'($urandom);
            ad_n = {$urandom, $urandom};
            wd_n = {$urandom, $urandom};
         end
      end
   endtask

   initial begin
      int lat;
      logic [5:0] seq;
      int ng;
      model_reset();
      #1 rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_strobes", {ram_read_en_o, ram_write_en_o}, 0);
      chk("rst_addr", ram_addr_o, 0);
      chk("rst_done", {m_done_o, d_done_o, m_gnt_o, d_gnt_o}, 0);
      chk("rst_rdata", m_rdata_o | d_rdata_o, 0);
      rst_n_i = 1'b1;

      // M write
      m_req_i = 1; m_we_i = 1; m_addr_i = 64'h100; m_wdata_i = 64'hDEADBEEF;
      step();
      chk("wr_gnt", got_gm, 1);
      m_req_i = 0;
      run_until_done("wr", lat);
      chk("wr_lat", lat, 2);
      chk("wr_rdata", got_mr, 0);
      chk("wr_err", got_me, 0);

      // M read with RAM returning 0x1234
      ram_rdata_i = 64'h1234;
      m_req_i = 1; m_we_i = 0; m_addr_i = 64'h200;
      step();
      m_req_i = 0;
      run_until_done("rd", lat);
      chk("rd_lat", lat, 2 + RL);
      chk("rd_rdata", got_mr, 64'h1234);

      // Both ports request continuously
      m_req_i = 1; m_we_i = 1; d_req_i = 1; d_we_i = 1; d_addr_i = 64'h40; d_wdata_i = 64'h77;
      seq = '0; ng = 0;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         step();
         if (got_gm || got_gd) begin seq = {seq[4:0], got_gd}; ng++; end
      end
      chk("starve_cnt", ng, 6);
      chk("starve_order", seq, 6'b000010);
      m_req_i = 0; d_req_i = 0;
      repeat (3) step();

      // D read with RAM error
      ram_err_i = 1;
      d_req_i = 1; d_we_i = 0; d_addr_i = 64'h8;
      step();
      chk("derr_gnt", got_gd, 1);
      d_req_i = 0;
      run_until_done("derr", lat);
      chk("derr_done", got_dd, 1);
      chk("derr_err", got_de, 1);
      chk("derr_mdone", got_md, 0);
      ram_err_i = 0;

      // Asynchronous reset while waiting on read latency
      m_req_i = 1; m_we_i = 0; m_addr_i = 64'h300;
      step();
      m_req_i = 0;
      step();
      rst_n_i = 0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_strobes", {ram_read_en_o, ram_write_en_o}, 0);
      chk("arst_addr", ram_addr_o, 0);
      chk("arst_done", {m_done_o, d_done_o}, 0);
      model_reset();
      @(posedge clk_i); #1;
      chk("arst_hold", busy_o, 0);
      rst_n_i = 1;
      ram_rdata_i = 64'h55AA;
      m_req_i = 1; m_we_i = 0; m_addr_i = 64'h308;
      step();
      m_req_i = 0;
      run_until_done("post_rst", lat);
      chk("post_rst_lat", lat, 2 + RL);
      chk("post_rst_rdata", got_mr, 64'h55AA);

      // M request withdrawn while D owns the RAM
      d_req_i = 1; d_we_i = 1; d_addr_i = 64'h10; d_wdata_i = 64'h99;
      step();
      d_req_i = 0; m_req_i = 1; m_we_i = 1; m_addr_i = 64'h20;
      step();
      m_req_i = 0;
      step();
      chk("drop_ddone", got_dd, 1);
      step();
      chk("drop_no_gnt", got_gm, 0);
      repeat (4) step();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rnd_port(m_req_i, e_gm, m_we_i, m_addr_i, m_wdata_i, m_req_i, m_we_i, m_addr_i, m_wdata_i);
         rnd_port(d_req_i, e_gd, d_we_i, d_addr_i, d_wdata_i, d_req_i, d_we_i, d_addr_i, d_wdata_i);
         ram_rdata_i = {$urandom, $urandom};
         ram_err_i = $urandom_range(0, 3) == 0;
         step();
      end
      m_req_i = 0; d_req_i = 0;
      repeat (8) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
